// File: rtl/msg_pkg.sv
// Types and default sizing shared by the receive-side assembler and the
// transmit-side disassembler.
package msg_pkg;

  localparam int MSG_WORD_SIZE        = 8;
  localparam int MSG_WORDS_PER_PACKET = 4;

  typedef enum logic [1:0] {
    SM_COLLECT = 2'd0,
    SM_WAIT    = 2'd1,
    SM_WRITE   = 2'd2
  } msg_asm_state_t;

endpackage

// File: rtl/msg_asm_gap_timer.sv
// Idle-gap counter for msg_asm: counts enabled cycles and pulses expire_o in
// the cycle the count reaches LIMIT; clr_i reloads the count to zero.
module gap_timer #(
  parameter int LIMIT = 16,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Expiry is combinational so the owner can act in the same cycle.
  always_comb begin
    expire_o = en_i && (cnt_q == W'(LIMIT - 1));
  end

  // Next count: reload on clear or expiry, otherwise advance when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/msg_asm.sv
// Packs WORDS_PER_PACKET UART words (word 0 in the LSBs) into one message and
// writes it to the command FIFO. Define MSG_ASM_TIMEOUT_EN for the gap timer.
module msg_asm
  import msg_pkg::*;
#(
  parameter int WORD_SIZE        = MSG_WORD_SIZE,
  parameter int WORDS_PER_PACKET = MSG_WORDS_PER_PACKET,
  parameter int TIMEOUT_CYCLES   = 1000000,
  parameter int CTR_WIDTH        = $clog2(WORDS_PER_PACKET + 1),
  localparam int OUTPUT_WIDTH    = WORD_SIZE * WORDS_PER_PACKET
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic [WORD_SIZE-1:0]    data_in,
  input  logic                    data_in_valid,
  input  logic                    fifo_full,
  output logic [OUTPUT_WIDTH-1:0] data_out,
  output logic                    data_out_req,
  output logic                    overrun,
  output logic                    timeout
);

  msg_asm_state_t          state_q, state_d;
  logic [CTR_WIDTH-1:0]    ctr_q, ctr_d;
  logic [OUTPUT_WIDTH-1:0] data_q, data_d;
  logic                    req_q, req_d;
  logic                    overrun_q, overrun_d;
  logic                    timeout_q, timeout_d;
  logic                    accept_s;
  logic                    last_s;
  logic                    expire_s;

  assign accept_s = (state_q == SM_COLLECT) && data_in_valid;
  assign last_s   = accept_s && (ctr_q == CTR_WIDTH'(WORDS_PER_PACKET - 1));

`ifdef MSG_ASM_TIMEOUT_EN
  logic timer_en_s;
  logic timer_clr_s;

  // Only a partial message ages; an accepted word restarts the gap.
  assign timer_en_s  = (state_q == SM_COLLECT) && (ctr_q != CTR_WIDTH'(0));
  assign timer_clr_s = accept_s || !timer_en_s;

  gap_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk      (clk),
    .n_reset  (n_reset),
    .clr_i    (timer_clr_s),
    .en_i     (timer_en_s),
    .expire_o (expire_s)
  );
`else
  assign expire_s = 1'b0;
`endif

  // State register and datapath registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= SM_COLLECT;
      ctr_q     <= '0;
      data_q    <= '0;
      req_q     <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      data_q    <= data_d;
      req_q     <= req_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SM_COLLECT: begin
        if (last_s) begin
          state_d = SM_WAIT;
        end else begin
          state_d = SM_COLLECT;
        end
      end
      SM_WAIT: begin
        if (!fifo_full) begin
          state_d = SM_WRITE;
        end else begin
          state_d = SM_WAIT;
        end
      end
      SM_WRITE: state_d = SM_COLLECT;
      default:  state_d = SM_COLLECT;
    endcase
  end

  // Word counter and message slots; an accepted word beats a gap expiry.
  always_comb begin
    ctr_d  = ctr_q;
    data_d = data_q;
    if (accept_s) begin
      ctr_d = ctr_q + CTR_WIDTH'(1);
      for (int i = 0; i < WORDS_PER_PACKET; i++) begin
        if (ctr_q == CTR_WIDTH'(i)) begin
          data_d[i*WORD_SIZE +: WORD_SIZE] = data_in;
        end else begin
          data_d[i*WORD_SIZE +: WORD_SIZE] = data_q[i*WORD_SIZE +: WORD_SIZE];
        end
      end
    end else if ((state_q == SM_WRITE) || expire_s) begin
      ctr_d = '0;
    end else begin
      ctr_d = ctr_q;
    end
  end

  // Output logic, registered so every strobe is a clean flop output.
  always_comb begin
    req_d     = (state_d == SM_WRITE);
    overrun_d = data_in_valid && (state_q != SM_COLLECT);
    timeout_d = expire_s && !accept_s;
  end

  assign data_out     = data_q;
  assign data_out_req = req_q;
  assign overrun      = overrun_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_msg_asm.sv
// Directed self-checking bench for msg_asm; timeout scenarios follow the
// MSG_ASM_TIMEOUT_EN build setting.
module tb_msg_asm;

  localparam int WS = 8;
  localparam int WPP = 4;
  localparam int TO = 16;
  localparam int OW = WS * WPP;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic [WS-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          fifo_full = 1'b0;
  logic [OW-1:0] data_out;
  logic          data_out_req;
  logic          overrun;
  logic          timeout;

  int checks = 0;
  int failures = 0;

  msg_asm #(
    .WORD_SIZE        (WS),
    .WORDS_PER_PACKET (WPP),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .fifo_full     (fifo_full),
    .data_out      (data_out),
    .data_out_req  (data_out_req),
    .overrun       (overrun),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One clock with the given inputs; returns #1 after the edge.
  task automatic step(input logic v, input logic [WS-1:0] d, input logic full);
    data_in_valid = v;
    data_in = d;
    fifo_full = full;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
  endtask

  initial begin
    int tp;
    logic [7:0] w;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", data_out, 32'h0);
    chk("rst_req", {31'b0, data_out_req}, 32'h0);
    chk("rst_ovr", {31'b0, overrun}, 32'h0);
    chk("rst_tmo", {31'b0, timeout}, 32'h0);
    n_reset = 1'b1;

    // Basic message, FIFO free.
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    chk("t1_data_complete", data_out, 32'h44332211);
    chk("t1_req_early", {31'b0, data_out_req}, 32'h0);
    step(1'b0, 8'h00, 1'b0);
    chk("t1_req", {31'b0, data_out_req}, 32'h1);
    chk("t1_data_write", data_out, 32'h44332211);
    step(1'b0, 8'h00, 1'b0);
    chk("t1_req_single", {31'b0, data_out_req}, 32'h0);

    // FIFO full for 10 cycles, one overrun word while waiting.
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(i == 3, 8'h55, 1'b1);
      chk("t2_req_full", {31'b0, data_out_req}, 32'h0);
      chk("t2_ovr", {31'b0, overrun}, (i == 3) ? 32'h1 : 32'h0);
    end
    chk("t2_data_kept", data_out, 32'h44332211);
    step(1'b0, 8'h00, 1'b0);
    chk("t2_req", {31'b0, data_out_req}, 32'h1);
    chk("t2_data_write", data_out, 32'h44332211);
    step(1'b0, 8'h00, 1'b0);
    chk("t2_req_single", {31'b0, data_out_req}, 32'h0);

    // Words every cycle: the SM_WAIT and SM_WRITE words are dropped.
    for (int j = 0; j < 12; j++) begin
      w = 8'(j + 1);
      step(1'b1, w, 1'b0);
      chk("t3_req", {31'b0, data_out_req}, (j == 4 || j == 10) ? 32'h1 : 32'h0);
      chk("t3_ovr", {31'b0, overrun}, (j == 4 || j == 5 || j == 10 || j == 11) ? 32'h1 : 32'h0);
      if (j == 4) chk("t3_msg_a", data_out, 32'h04030201);
      if (j == 10) chk("t3_msg_b", data_out, 32'h0A090807);
    end

    // Asynchronous reset mid-message.
    step(1'b1, 8'hDE, 1'b0);
    step(1'b1, 8'hAD, 1'b0);
    #2;
    n_reset = 1'b0;
    #1;
    chk("t4_rst_data", data_out, 32'h0);
    chk("t4_rst_req", {31'b0, data_out_req}, 32'h0);
    chk("t4_rst_ovr", {31'b0, overrun}, 32'h0);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    step(1'b1, 8'h21, 1'b0);
    step(1'b1, 8'h43, 1'b0);
    step(1'b1, 8'h65, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t4_no_early_req", {31'b0, data_out_req}, 32'h0);
    step(1'b1, 8'h87, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t4_req", {31'b0, data_out_req}, 32'h1);
    chk("t4_data", data_out, 32'h87654321);
    step(1'b0, 8'h00, 1'b0);

    // Word exactly in the expiry cycle is accepted in either build.
    tp = 0;
    step(1'b1, 8'h31, 1'b0);
    step(1'b1, 8'h32, 1'b0);
    for (int i = 0; i < TO - 1; i++) begin
      step(1'b0, 8'h00, 1'b0);
      tp += int'(timeout);
    end
    step(1'b1, 8'h33, 1'b0);
    tp += int'(timeout);
    step(1'b1, 8'h34, 1'b0);
    tp += int'(timeout);
    step(1'b0, 8'h00, 1'b0);
    tp += int'(timeout);
    chk("t5_edge_tmo_count", 32'(tp), 32'h0);
    chk("t5_edge_req", {31'b0, data_out_req}, 32'h1);
    chk("t5_edge_data", data_out, 32'h34333231);
    step(1'b0, 8'h00, 1'b0);

    // Two words, 20-cycle gap.
    tp = 0;
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'h00, 1'b0);
      tp += int'(timeout);
`ifdef MSG_ASM_TIMEOUT_EN
      chk("t6_tmo_pulse", {31'b0, timeout}, (i == TO - 1) ? 32'h1 : 32'h0);
`endif
    end
`ifdef MSG_ASM_TIMEOUT_EN
    chk("t6_tmo_count", 32'(tp), 32'h1);
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    chk("t6_no_early_req", {31'b0, data_out_req}, 32'h0);
    step(1'b1, 8'hC4, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t6_req", {31'b0, data_out_req}, 32'h1);
    chk("t6_data", data_out, 32'hC4C3C2C1);
`else
    chk("t6_tmo_count", 32'(tp), 32'h0);
    step(1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'hC4, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t6_req", {31'b0, data_out_req}, 32'h1);
    chk("t6_data", data_out, 32'hC4C30201);
`endif
    step(1'b0, 8'h00, 1'b0);
    chk("t6_req_single", {31'b0, data_out_req}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
